// File: rtl/bsu_pkg.sv
// rtl/bsu_pkg.sv - shared encodings for the bitfield shift unit
package bsu_pkg;

  typedef enum logic [1:0] {
    OP_SHL = 2'b00,
    OP_SHR = 2'b01,
    OP_ASR = 2'b10,
    OP_BFE = 2'b11
  } bsu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LEFT  = 2'b01,
    ST_RIGHT = 2'b10,
    ST_DONE  = 2'b11
  } bsu_state_e;

  // Right fill comes from the current msb for arithmetic-style right shifts.
  function automatic logic sign_fill_op(input bsu_op_e op, input logic signed_bfe);
    return (op == OP_ASR) || ((op == OP_BFE) && signed_bfe);
  endfunction

endpackage

// File: rtl/bsu_step_shifter.sv
// rtl/bsu_step_shifter.sv - combinational shift of up to STEP bits with fill and carry-out
module bsu_step_shifter #(
  parameter int DATA_W = 16,
  parameter int AMT_W  = 5
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [AMT_W-1:0]  i_amt,
  input  logic              i_left,
  input  logic              i_fill,
  output logic [DATA_W-1:0] o_data,
  output logic              o_carry
);

  localparam logic [AMT_W-1:0]  W_C    = AMT_W'(DATA_W);
  localparam logic [AMT_W-1:0]  ONE_C  = AMT_W'(1);
  localparam logic [DATA_W-1:0] ONES_C = '1;

  logic [DATA_W-1:0] w_fill_mask;
  logic [DATA_W-1:0] w_probe;

  // w_probe brings the last bit leaving the word down to bit 0.
  always_comb begin
    w_fill_mask = ~(ONES_C >> i_amt);
    if (i_left) begin
      o_data  = i_data << i_amt;
      w_probe = i_data >> (W_C - i_amt);
    end else begin
      o_data  = (i_data >> i_amt) | (i_fill ? w_fill_mask : '0);
      w_probe = i_data >> (i_amt - ONE_C);
    end
    o_carry = (i_amt != '0) && w_probe[0];
  end

endmodule

// File: rtl/bitfield_shift_unit.sv
// rtl/bitfield_shift_unit.sv - multi-cycle SHL/SHR/ASR/BFE unit with valid/ready handshakes
// BSU_SIGNED_BFE_EN: when defined, BFE results are sign-extended from the field msb.
module bitfield_shift_unit #(
  parameter int DATA_W = 16,
  parameter int STEP   = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [1:0]                 i_op,
  input  logic [DATA_W-1:0]          i_src,
  input  logic [$clog2(DATA_W)-1:0]  i_field_hi,
  input  logic [$clog2(DATA_W)-1:0]  i_field_lo,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [DATA_W-1:0]          o_result,
  output logic                       o_carry,
  output logic                       o_zero,
  output logic                       o_err
);

  import bsu_pkg::*;

  localparam int SHAMT_W = $clog2(DATA_W);
  localparam int AMT_W   = SHAMT_W + 1;
  localparam logic [AMT_W-1:0] STEP_C = AMT_W'(STEP);
  localparam logic [AMT_W-1:0] WM1_C  = AMT_W'(DATA_W - 1);

`ifdef BSU_SIGNED_BFE_EN
  localparam logic SIGNED_BFE = 1'b1;
`else
  localparam logic SIGNED_BFE = 1'b0;
`endif

  bsu_state_e        r_state;
  bsu_op_e           r_op;
  logic [DATA_W-1:0] r_data;
  logic [AMT_W-1:0]  r_lcnt;
  logic [AMT_W-1:0]  r_rcnt;
  logic              r_carry;
  logic              r_err;

  bsu_op_e           w_op_in;
  logic [AMT_W-1:0]  w_acc_l;
  logic [AMT_W-1:0]  w_acc_r;
  logic              w_bfe_err;
  logic              w_in_left;
  logic [AMT_W-1:0]  w_rem;
  logic [AMT_W-1:0]  w_amt;
  logic              w_fill;
  logic [DATA_W-1:0] w_sh_data;
  logic              w_sh_carry;

  // BFE moves the field msb up to the word msb, then right-aligns the field lsb.
  always_comb begin
    w_op_in   = bsu_op_e'(i_op);
    w_acc_l   = '0;
    w_acc_r   = '0;
    w_bfe_err = 1'b0;
    case (w_op_in)
      OP_SHL: w_acc_l = {1'b0, i_field_lo};
      OP_SHR,
      OP_ASR: w_acc_r = {1'b0, i_field_lo};
      default: begin
        w_acc_l   = WM1_C - {1'b0, i_field_hi};
        w_acc_r   = w_acc_l + {1'b0, i_field_lo};
        w_bfe_err = (i_field_hi < i_field_lo);
      end
    endcase
  end

  always_comb begin
    w_in_left = (r_state == ST_LEFT);
    w_rem     = w_in_left ? r_lcnt : r_rcnt;
    w_amt     = (w_rem > STEP_C) ? STEP_C : w_rem;
    w_fill    = sign_fill_op(r_op, SIGNED_BFE) && r_data[DATA_W-1];
  end

  bsu_step_shifter #(
    .DATA_W (DATA_W),
    .AMT_W  (AMT_W)
  ) u_step_shifter (
    .i_data  (r_data),
    .i_amt   (w_amt),
    .i_left  (w_in_left),
    .i_fill  (w_fill),
    .o_data  (w_sh_data),
    .o_carry (w_sh_carry)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= OP_SHL;
      r_data  <= '0;
      r_lcnt  <= '0;
      r_rcnt  <= '0;
      r_carry <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_in_valid) begin
            r_op    <= w_op_in;
            r_carry <= 1'b0;
            r_err   <= w_bfe_err;
            if (w_bfe_err) begin
              r_data  <= '0;
              r_lcnt  <= '0;
              r_rcnt  <= '0;
              r_state <= ST_DONE;
            end else begin
              r_data <= i_src;
              r_lcnt <= w_acc_l;
              r_rcnt <= w_acc_r;
              if (w_acc_l != '0)      r_state <= ST_LEFT;
              else if (w_acc_r != '0) r_state <= ST_RIGHT;
              else                    r_state <= ST_DONE;
            end
          end
        end
        ST_LEFT: begin
          r_data  <= w_sh_data;
          r_lcnt  <= r_lcnt - w_amt;
          r_carry <= (r_op != OP_BFE) && w_sh_carry;
          if (r_lcnt == w_amt) begin
            r_state <= (r_rcnt != '0) ? ST_RIGHT : ST_DONE;
          end
        end
        ST_RIGHT: begin
          r_data  <= w_sh_data;
          r_rcnt  <= r_rcnt - w_amt;
          r_carry <= (r_op != OP_BFE) && w_sh_carry;
          if (r_rcnt == w_amt) begin
            r_state <= ST_DONE;
          end
        end
        default: begin
          if (i_out_ready) begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign o_in_ready  = (r_state == ST_IDLE);
  assign o_out_valid = (r_state == ST_DONE);
  assign o_result    = r_data;
  assign o_carry     = r_carry;
  assign o_zero      = (r_state == ST_DONE) && (r_data == '0);
  assign o_err       = r_err;

endmodule

// File: tb/tb_bitfield_shift_unit.sv
// tb/tb_bitfield_shift_unit.sv - directed self-checking bench for bitfield_shift_unit
module tb_bitfield_shift_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [15:0] src;
  logic [3:0]  field_hi;
  logic [3:0]  field_lo;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        carry;
  logic        zero;
  logic        err;

  int n_tests;
  int n_fail;

  bitfield_shift_unit #(.DATA_W(16), .STEP(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_op        (op),
    .i_src       (src),
    .i_field_hi  (field_hi),
    .i_field_lo  (field_lo),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_result    (result),
    .o_carry     (carry),
    .o_zero      (zero),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_op(input logic [1:0] t_op, input logic [15:0] t_src,
                        input logic [3:0] t_hi, input logic [3:0] t_lo,
                        output int lat, output logic [15:0] r,
                        output logic c, output logic z, output logic e);
    @(negedge clk);
    op = t_op; src = t_src; field_hi = t_hi; field_lo = t_lo;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    r = result; c = carry; z = zero; e = err;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 2'b00; src = '0; field_hi = '0; field_lo = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || result !== 16'h0 || carry !== 1'b0 || zero !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b result=%h carry=%b zero=%b err=%b, required all 0",
               out_valid, result, carry, zero, err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_shl;
    int lat; logic [15:0] r; logic c, z, e;
    run_op(2'b00, 16'h8001, 4'd0, 4'd1, lat, r, c, z, e);
    n_tests++;
    if (r !== 16'h0002 || c !== 1'b1 || z !== 1'b0 || e !== 1'b0 || lat !== 2) begin
      n_fail++;
      $display("FAIL shl_8001_1: result=%h carry=%b zero=%b err=%b lat=%0d, required 0002 1 0 0 2", r, c, z, e, lat);
    end
    run_op(2'b00, 16'h1234, 4'd0, 4'd0, lat, r, c, z, e);
    n_tests++;
    if (r !== 16'h1234 || c !== 1'b0 || lat !== 1) begin
      n_fail++;
      $display("FAIL shl_zero_amt: result=%h carry=%b lat=%0d, required 1234 0 1", r, c, lat);
    end
  endtask

  task automatic test_bfe;
    int lat; logic [15:0] r; logic c, z, e; logic [15:0] exp_r;
`ifdef BSU_SIGNED_BFE_EN
    exp_r = 16'hFFBC;
`else
    exp_r = 16'h00BC;
`endif
    run_op(2'b11, 16'hABCD, 4'd11, 4'd4, lat, r, c, z, e);
    n_tests++;
    if (r !== exp_r || c !== 1'b0 || e !== 1'b0 || z !== 1'b0 || lat !== 4) begin
      n_fail++;
      $display("FAIL bfe_11_4: result=%h carry=%b err=%b zero=%b lat=%0d, required %h 0 0 0 4", r, c, e, z, lat, exp_r);
    end
    run_op(2'b11, 16'hABCD, 4'd15, 4'd0, lat, r, c, z, e);
    n_tests++;
    if (r !== 16'hABCD || e !== 1'b0 || lat !== 1) begin
      n_fail++;
      $display("FAIL bfe_full: result=%h err=%b lat=%0d, required abcd 0 1", r, e, lat);
    end
  endtask

  task automatic test_right_shifts;
    int lat; logic [15:0] r; logic c, z, e;
    run_op(2'b10, 16'h8000, 4'd0, 4'd15, lat, r, c, z, e);
    n_tests++;
    if (r !== 16'hFFFF || c !== 1'b0 || lat !== 5) begin
      n_fail++;
      $display("FAIL asr_8000_15: result=%h carry=%b lat=%0d, required ffff 0 5", r, c, lat);
    end
    run_op(2'b01, 16'h8000, 4'd0, 4'd15, lat, r, c, z, e);
    n_tests++;
    if (r !== 16'h0001 || c !== 1'b0 || lat !== 5) begin
      n_fail++;
      $display("FAIL shr_8000_15: result=%h carry=%b lat=%0d, required 0001 0 5", r, c, lat);
    end
    run_op(2'b10, 16'h432F, 4'd0, 4'd4, lat, r, c, z, e);
    n_tests++;
    if (r !== 16'h0432 || c !== 1'b1 || lat !== 2) begin
      n_fail++;
      $display("FAIL asr_pos: result=%h carry=%b lat=%0d, required 0432 1 2", r, c, lat);
    end
    run_op(2'b01, 16'h000F, 4'd0, 4'd4, lat, r, c, z, e);
    n_tests++;
    if (r !== 16'h0000 || c !== 1'b1 || z !== 1'b1 || lat !== 2) begin
      n_fail++;
      $display("FAIL shr_to_zero: result=%h carry=%b zero=%b lat=%0d, required 0000 1 1 2", r, c, z, lat);
    end
  endtask

  task automatic test_bfe_err;
    int lat; logic [15:0] r; logic c, z, e;
    run_op(2'b11, 16'hFFFF, 4'd3, 4'd5, lat, r, c, z, e);
    n_tests++;
    if (r !== 16'h0000 || e !== 1'b1 || z !== 1'b1 || c !== 1'b0 || lat !== 1) begin
      n_fail++;
      $display("FAIL bfe_err: result=%h err=%b zero=%b carry=%b lat=%0d, required 0000 1 1 0 1", r, e, z, c, lat);
    end
  endtask

  task automatic test_hold;
    int lat; int bad;
    @(negedge clk);
    op = 2'b00; src = 16'h00F0; field_hi = '0; field_lo = 4'd9;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    n_tests++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL hold_latency: got %0d, required 4", lat);
    end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (result !== 16'hE000 || carry !== 1'b1 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL hold_stable: %0d unstable cycles, required 0 (result=%h carry=%b)", bad, result, carry);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release: valid=%b ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid;
    int lat; logic [15:0] r; logic c, z, e;
    @(negedge clk);
    op = 2'b00; src = 16'hFFFF; field_hi = '0; field_lo = 4'd15;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (result !== 16'hFFF0 || carry !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_left_step: result=%h carry=%b valid=%b, required fff0 1 0", result, carry, out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || result !== 16'h0 || carry !== 1'b0 || zero !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: valid=%b result=%h carry=%b zero=%b err=%b, required all 0",
               out_valid, result, carry, zero, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_idle: ready=%b valid=%b, required 1 0", in_ready, out_valid);
    end
    run_op(2'b00, 16'h0003, 4'd0, 4'd2, lat, r, c, z, e);
    n_tests++;
    if (r !== 16'h000C || c !== 1'b0 || lat !== 2) begin
      n_fail++;
      $display("FAIL post_reset_op: result=%h carry=%b lat=%0d, required 000c 0 2", r, c, lat);
    end
  endtask

  task automatic test_back_to_back;
    int n_valid; int n_bad; int n_both;
    n_valid = 0; n_bad = 0; n_both = 0;
    @(negedge clk);
    op = 2'b00; src = 16'h1234; field_hi = '0; field_lo = 4'd0;
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        n_valid++;
        if (result !== 16'h1234) n_bad++;
      end
      if (in_ready === 1'b1 && out_valid === 1'b1) n_both++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    n_tests++;
    if (n_valid !== 6 || n_bad !== 0 || n_both !== 0) begin
      n_fail++;
      $display("FAIL back_to_back: results=%0d bad=%0d overlap=%0d, required 6 0 0", n_valid, n_bad, n_both);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_shl();
    test_bfe();
    test_right_shifts();
    test_bfe_err();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
